// File: rtl/param_seq_multiplier.sv
// Parametrised shift-add sequential multiplier with St/Done handshake.
// Signed mode multiplies magnitudes and negates the product at the end.
module param_seq_multiplier #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 St,
    input  logic                 Signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Result
);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e               state_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_step;

    // The magnitude of the most negative value still fits as a WIDTH-bit unsigned number.
    always_comb begin
        mag_a = A;
        mag_b = B;
        if (Signed_mode && A[WIDTH-1]) mag_a = -A;
        if (Signed_mode && B[WIDTH-1]) mag_b = -B;
    end

    always_comb begin
        acc_step = acc_q;
        if (mplier_q[0]) acc_step = acc_q + mcand_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (St) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(WIDTH);
                        neg_q    <= Signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                        Busy     <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    // Counter reaches zero after WIDTH steps; the next edge publishes the product.
                    if (cnt_q == '0) begin
                        Result  <= neg_q ? -acc_q : acc_q;
                        Done    <= 1'b1;
                        state_q <= StFin;
                    end else begin
                        acc_q    <= acc_step;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CNT_W'(1);
                    end
                end
                StFin: begin
                    Done    <= 1'b0;
                    Busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/param_seq_multiplier.md
Name: param_seq_multiplier

Overview:
- Parametrised shift-add sequential multiplier.
- Generalises the fixed 8-bit start/done multiplier to any operand width WIDTH.
- Adds per-operation signed/unsigned mode, a Busy flag and an asynchronous active-low reset.
- Sits wherever the datapath needs an area-cheap product.
- Uses the same St/Done handshake, so existing benches and controllers can drive it unchanged.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; Result is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the internal step counter; derived, not overridden.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- St  input  1  start request; level-sampled, accepted only in IDLE.
- Signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with St.
- A  input  WIDTH  multiplicand; sampled with St.
- B  input  WIDTH  multiplier; sampled with St.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse when Result is valid.
- Result  output  2*WIDTH  product; held until the next Done.

Behaviour:
- Reset (Rst_n low, asynchronous): state=IDLE, Busy=0, Done=0, Result=0, internal registers=0. This takes effect immediately, including mid-operation; the in-flight operation is discarded and no Done is produced after reset releases.
- States: IDLE, CALC, FIN.
- IDLE, St=1 at edge k: capture operands and enter CALC.
  - Signed_mode=1: capture |A| and |B| as WIDTH-bit unsigned magnitudes, and neg_flag = A[MSB] XOR B[MSB]. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH bits.
  - Signed_mode=0: capture A and B unchanged; neg_flag=0.
  - Clear the 2*WIDTH accumulator; set counter=WIDTH.
- IDLE, St=0: remain in IDLE.
- CALC, edges k+1..k+WIDTH: one step per edge.
  - If the multiplier LSB is 1, add the multiplicand (shifted by the step index) to the accumulator.
  - Shift the multiplier right and decrement the counter.
  - Leave CALC when the counter reaches 0.
- FIN entry, edge k+WIDTH+1:
  - Result <= neg_flag ? two's-complement negation of accumulator : accumulator.
  - Done <= 1.
- FIN, edge k+WIDTH+2: Done <= 0, state <= IDLE.
- Latency: Done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+1 cycles after St is accepted.
- Busy is high from edge k through edge k+WIDTH+2.
- St while Busy=1 is ignored. A, B and Signed_mode changes while Busy have no effect on the current operation.
- With St held high continuously, a new operation starts at the first IDLE edge. Throughput is one product per WIDTH+3 cycles.
- Result is updated only at FIN entry and is stable at all other times, including while a later operation is in CALC.
- Width rules:
  - The accumulator never overflows; the maximum unsigned product (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - Signed extremes fit in 2*WIDTH-bit two's complement. (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) is positive and representable.
- Zero operands take the same WIDTH+1 latency; there is no early termination.

Test Plan:
- WIDTH=8, reset then St=1, A=10, B=5, Signed_mode=0 -> Busy=1 the cycle after St is accepted; Done pulses exactly 9 cycles after acceptance with Result=16'd50; Busy=0 one cycle later.
- WIDTH=8, change A=15, B=4 mid-operation with St held high -> current op still yields 50. The next op starts in IDLE and yields Result=16'd60. Done is a single-cycle pulse for each op, 11 cycles apart.
- WIDTH=8, Signed_mode=1, A=-3 (8'hFD), B=7 -> Result=16'hFFEB (-21). Then A=8'h80, B=8'h80 -> Result=16'h4000 (16384).
- WIDTH=8, Signed_mode=0: A=8'hFF, B=8'hFF -> Result=16'hFE01. Then A=0, B=8'hAB -> Result=0 after the full 9-cycle latency.
- WIDTH=8, Rst_n pulsed low at step 4 of CALC -> Busy, Done and Result read 0 immediately (asynchronous); no Done follows; the next St produces a correct product.
- WIDTH=4 instance, Signed_mode=1, A=4'h8, B=4'h7 -> Result=8'hC8 (-56), Done 5 cycles after acceptance.
